// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for the five-stage in-order core.
// Decides every cycle which pipeline registers advance, hold or take a bubble.
// It also sequences the multi-cycle mul/div unit and keeps saturating
// stall/flush counters. The control decisions are combinational, so they take
// effect in the same cycle. The FSM state and the counters are registered.
module pipe_ctrl #(
    parameter int REG_INDEX_SIZE = 5,
    parameter int CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pipe_ctrl_id_rs1_en_i,
    input  logic                      pipe_ctrl_id_rs2_en_i,
    input  logic [REG_INDEX_SIZE-1:0] pipe_ctrl_id_rs1_index_i,
    input  logic [REG_INDEX_SIZE-1:0] pipe_ctrl_id_rs2_index_i,
    input  logic                      pipe_ctrl_id2ex_valid_i,
    input  logic                      pipe_ctrl_id2ex_load_i,
    input  logic                      pipe_ctrl_id2ex_rd_en_i,
    input  logic [REG_INDEX_SIZE-1:0] pipe_ctrl_id2ex_rd_index_i,
    input  logic                      pipe_ctrl_ex_md_i,
    input  logic                      pipe_ctrl_md_done_i,
    input  logic                      pipe_ctrl_redirect_i,
    input  logic                      pipe_ctrl_mem_req_i,
    input  logic                      pipe_ctrl_mem_ack_i,
    output logic                      pipe_ctrl_md_start_o,
    output logic                      pipe_ctrl_pc_en_o,
    output logic                      pipe_ctrl_if2id_en_o,
    output logic                      pipe_ctrl_id2ex_en_o,
    output logic                      pipe_ctrl_ex2mem_en_o,
    output logic                      pipe_ctrl_mem2wb_en_o,
    output logic                      pipe_ctrl_if2id_flush_o,
    output logic                      pipe_ctrl_id2ex_flush_o,
    output logic                      pipe_ctrl_ex2mem_bubble_o,
    output logic                      pipe_ctrl_mem2wb_bubble_o,
    output logic [1:0]                pipe_ctrl_state_o,
    output logic [CNT_W-1:0]          pipe_ctrl_stall_cnt_o,
    output logic [CNT_W-1:0]          pipe_ctrl_flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_MD_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_reg;
    state_t state_next;

    // Hazard terms.
    logic mem_stall;
    logic md_launch;
    logic md_finish;
    logic ex_hold;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic redirect_take;

    // Ungated control decisions. They are forced to zero while reset is held.
    logic pc_en_next;
    logic if2id_en_next;
    logic id2ex_en_next;
    logic ex2mem_en_next;
    logic mem2wb_en_next;
    logic if2id_flush_next;
    logic id2ex_flush_next;
    logic ex2mem_bubble_next;
    logic mem2wb_bubble_next;

    // Counter array: index 0 counts stall cycles, index 1 counts flush cycles.
    logic [CNT_W-1:0] cnt_reg [2];
    logic [1:0]       cnt_inc;

    // Hazard detection. Only hazards that forwarding cannot cover are
    // interlocked here.
    always_comb begin
        mem_stall = pipe_ctrl_mem_req_i & ~pipe_ctrl_mem_ack_i;
        md_launch = (state_reg == ST_RUN) & pipe_ctrl_id2ex_valid_i & pipe_ctrl_ex_md_i;
        // The result may leave EX only if MEM is able to accept it this cycle.
        md_finish = pipe_ctrl_md_done_i & ~mem_stall;
        ex_hold   = md_launch
                  | ((state_reg == ST_MD_WAIT) & ~md_finish)
                  | ((state_reg == ST_MD_DONE) & mem_stall);
        rs1_hit   = pipe_ctrl_id_rs1_en_i
                  & (pipe_ctrl_id_rs1_index_i == pipe_ctrl_id2ex_rd_index_i);
        rs2_hit   = pipe_ctrl_id_rs2_en_i
                  & (pipe_ctrl_id_rs2_index_i == pipe_ctrl_id2ex_rd_index_i);
        // x0 is never a real dependency, so a load to x0 never interlocks.
        load_use  = pipe_ctrl_id2ex_valid_i & pipe_ctrl_id2ex_load_i
                  & pipe_ctrl_id2ex_rd_en_i
                  & (pipe_ctrl_id2ex_rd_index_i != '0)
                  & (rs1_hit | rs2_hit);
        redirect_take = pipe_ctrl_redirect_i & pipe_ctrl_id2ex_valid_i;
    end

    // Mul/div sequencing. The done signal matters only while a result is awaited.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (md_launch) begin
                    state_next = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                if (pipe_ctrl_md_done_i) begin
                    state_next = mem_stall ? ST_MD_DONE : ST_RUN;
                end
            end
            ST_MD_DONE: begin
                if (!mem_stall) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Prioritised stall/flush decision. The first matching hazard wins.
    // A redirect outranks load-use because the dependent ID instruction is
    // squashed anyway.
    always_comb begin
        pc_en_next         = 1'b1;
        if2id_en_next      = 1'b1;
        id2ex_en_next      = 1'b1;
        ex2mem_en_next     = 1'b1;
        mem2wb_en_next     = 1'b1;
        if2id_flush_next   = 1'b0;
        id2ex_flush_next   = 1'b0;
        ex2mem_bubble_next = 1'b0;
        mem2wb_bubble_next = 1'b0;
        if (mem_stall) begin
            // MEM is blocked. Everything up to EX/MEM holds, and WB receives a bubble.
            pc_en_next         = 1'b0;
            if2id_en_next      = 1'b0;
            id2ex_en_next      = 1'b0;
            ex2mem_en_next     = 1'b0;
            mem2wb_bubble_next = 1'b1;
        end else if (ex_hold) begin
            // EX is occupied by mul/div. Upstream holds, and MEM receives a bubble.
            pc_en_next         = 1'b0;
            if2id_en_next      = 1'b0;
            id2ex_en_next      = 1'b0;
            ex2mem_bubble_next = 1'b1;
        end else if (redirect_take) begin
            // EX advances with a taken control transfer. Squash the two younger slots.
            if2id_flush_next   = 1'b1;
            id2ex_flush_next   = 1'b1;
        end else if (load_use) begin
            // The loaded value is not forwardable yet. Insert exactly one bubble into EX.
            pc_en_next         = 1'b0;
            if2id_en_next      = 1'b0;
            id2ex_flush_next   = 1'b1;
        end
    end

    // Control outputs. They read zero while reset is asserted.
    assign pipe_ctrl_md_start_o      = md_launch          & rst_n;
    assign pipe_ctrl_pc_en_o         = pc_en_next         & rst_n;
    assign pipe_ctrl_if2id_en_o      = if2id_en_next      & rst_n;
    assign pipe_ctrl_id2ex_en_o      = id2ex_en_next      & rst_n;
    assign pipe_ctrl_ex2mem_en_o     = ex2mem_en_next     & rst_n;
    assign pipe_ctrl_mem2wb_en_o     = mem2wb_en_next     & rst_n;
    assign pipe_ctrl_if2id_flush_o   = if2id_flush_next   & rst_n;
    assign pipe_ctrl_id2ex_flush_o   = id2ex_flush_next   & rst_n;
    assign pipe_ctrl_ex2mem_bubble_o = ex2mem_bubble_next & rst_n;
    assign pipe_ctrl_mem2wb_bubble_o = mem2wb_bubble_next & rst_n;
    assign pipe_ctrl_state_o         = state_reg;

    // FSM state register. Reset returns to RUN, even in the middle of an operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counter increment conditions, taken from the gated outputs.
    assign cnt_inc[0] = ~pipe_ctrl_pc_en_o;
    assign cnt_inc[1] = pipe_ctrl_if2id_flush_o;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            // Saturating event counter. It stops at all-ones instead of wrapping.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
                end
            end
        end
    endgenerate

    assign pipe_ctrl_stall_cnt_o = cnt_reg[0];
    assign pipe_ctrl_flush_cnt_o = cnt_reg[1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. Directed scenarios followed by random cycles.
// Every cycle, all outputs are compared against a reference model that keeps
// track of the mul/div occupancy of EX.
module tb_pipe_ctrl;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          rs1_en, rs2_en;
    logic [RW-1:0] rs1, rs2;
    logic          ex_valid, ex_load, ex_rd_en;
    logic [RW-1:0] ex_rd;
    logic          ex_md, md_done, redirect, mem_req, mem_ack;
    logic          md_start, pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en;
    logic          if2id_flush, id2ex_flush, ex2mem_bubble, mem2wb_bubble;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    // m_md_phase: 0 = EX free of mul/div, 1 = awaiting result,
    //             2 = result ready but MEM blocked.
    int m_md_phase;
    int m_stall;
    int m_flush;
    // Expected values for the current cycle.
    // Register order: 0 pc, 1 if2id, 2 id2ex, 3 ex2mem, 4 mem2wb.
    logic       e_en  [5];
    logic       e_bub [5];
    logic       e_start;

    pipe_ctrl #(.REG_INDEX_SIZE(RW), .CNT_W(CW)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .pipe_ctrl_id_rs1_en_i      (rs1_en),
        .pipe_ctrl_id_rs2_en_i      (rs2_en),
        .pipe_ctrl_id_rs1_index_i   (rs1),
        .pipe_ctrl_id_rs2_index_i   (rs2),
        .pipe_ctrl_id2ex_valid_i    (ex_valid),
        .pipe_ctrl_id2ex_load_i     (ex_load),
        .pipe_ctrl_id2ex_rd_en_i    (ex_rd_en),
        .pipe_ctrl_id2ex_rd_index_i (ex_rd),
        .pipe_ctrl_ex_md_i          (ex_md),
        .pipe_ctrl_md_done_i        (md_done),
        .pipe_ctrl_redirect_i       (redirect),
        .pipe_ctrl_mem_req_i        (mem_req),
        .pipe_ctrl_mem_ack_i        (mem_ack),
        .pipe_ctrl_md_start_o       (md_start),
        .pipe_ctrl_pc_en_o          (pc_en),
        .pipe_ctrl_if2id_en_o       (if2id_en),
        .pipe_ctrl_id2ex_en_o       (id2ex_en),
        .pipe_ctrl_ex2mem_en_o      (ex2mem_en),
        .pipe_ctrl_mem2wb_en_o      (mem2wb_en),
        .pipe_ctrl_if2id_flush_o    (if2id_flush),
        .pipe_ctrl_id2ex_flush_o    (id2ex_flush),
        .pipe_ctrl_ex2mem_bubble_o  (ex2mem_bubble),
        .pipe_ctrl_mem2wb_bubble_o  (mem2wb_bubble),
        .pipe_ctrl_state_o          (state),
        .pipe_ctrl_stall_cnt_o      (stall_cnt),
        .pipe_ctrl_flush_cnt_o      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rs1_en = 0; rs2_en = 0; rs1 = 0; rs2 = 0;
        ex_valid = 0; ex_load = 0; ex_rd_en = 0; ex_rd = 0;
        ex_md = 0; md_done = 0; redirect = 0; mem_req = 0; mem_ack = 0;
    endtask

    // Computes the expected outputs from the rules. The number of leading
    // registers that hold is worked out first. The first register that still
    // advances behind a held register loads a bubble.
    task automatic model_eval();
        bit ms, busy, lu;
        int frozen;
        for (int i = 0; i < 5; i++) begin
            e_en[i] = 0;
            e_bub[i] = 0;
        end
        e_start = 0;
        if (!rst_n) begin
            m_md_phase = 0;
            m_stall = 0;
            m_flush = 0;
            return;
        end
        ms = mem_req && !mem_ack;
        busy = (m_md_phase == 0 && ex_valid && ex_md)
            || (m_md_phase == 1 && !(md_done && !ms))
            || (m_md_phase == 2 && ms);
        lu = ex_valid && ex_load && ex_rd_en && ex_rd != 0
            && ((rs1_en && rs1 == ex_rd) || (rs2_en && rs2 == ex_rd));
        e_start = (m_md_phase == 0) && ex_valid && ex_md;
        frozen = 0;
        if (ms) frozen = 4;
        else if (busy) frozen = 3;
        else if (!(redirect && ex_valid) && lu) frozen = 2;
        for (int i = 0; i < 5; i++) begin
            e_en[i]  = (i >= frozen);
            e_bub[i] = (frozen > 0) && (i == frozen);
        end
        if (!ms && !busy && redirect && ex_valid) begin
            e_bub[1] = 1;
            e_bub[2] = 1;
        end
    endtask

    // Clock-edge update of the model.
    task automatic model_update();
        bit ms;
        if (!rst_n) return;
        ms = mem_req && !mem_ack;
        if (!e_en[0] && m_stall < 15) m_stall++;
        if (e_bub[1] && m_flush < 15) m_flush++;
        case (m_md_phase)
            0: if (ex_valid && ex_md) m_md_phase = 1;
            1: if (md_done) m_md_phase = ms ? 2 : 0;
            default: if (!ms) m_md_phase = 0;
        endcase
    endtask

    // One cycle. Inputs are already driven. The check happens at the falling
    // edge. The model then advances at the rising edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, ".md_start"},      32'(md_start),      32'(e_start));
        chk({tag, ".pc_en"},         32'(pc_en),         32'(e_en[0]));
        chk({tag, ".if2id_en"},      32'(if2id_en),      32'(e_en[1]));
        chk({tag, ".id2ex_en"},      32'(id2ex_en),      32'(e_en[2]));
        chk({tag, ".ex2mem_en"},     32'(ex2mem_en),     32'(e_en[3]));
        chk({tag, ".mem2wb_en"},     32'(mem2wb_en),     32'(e_en[4]));
        chk({tag, ".if2id_flush"},   32'(if2id_flush),   32'(e_bub[1]));
        chk({tag, ".id2ex_flush"},   32'(id2ex_flush),   32'(e_bub[2]));
        chk({tag, ".ex2mem_bubble"}, 32'(ex2mem_bubble), 32'(e_bub[3]));
        chk({tag, ".mem2wb_bubble"}, 32'(mem2wb_bubble), 32'(e_bub[4]));
        chk({tag, ".state"},         32'(state),         32'(m_md_phase));
        chk({tag, ".stall_cnt"},     32'(stall_cnt),     32'(m_stall));
        chk({tag, ".flush_cnt"},     32'(flush_cnt),     32'(m_flush));
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        m_md_phase = 0; m_stall = 0; m_flush = 0;
        idle_inputs();
        rst_n = 0;
        // Reset: all outputs are zero.
        cycle("reset0");
        cycle("reset1");
        rst_n = 1;
        #1;
        cycle("idle");

        // Load-use: load x5 is in EX and ID reads rs2 = x5. One bubble is inserted.
        ex_valid = 1; ex_load = 1; ex_rd_en = 1; ex_rd = 5; rs2_en = 1; rs2 = 5;
        cycle("lu_stall");
        chk("lu_stall_cnt_after", 32'(stall_cnt), 32'd1);
        ex_load = 0; ex_rd_en = 0; ex_rd = 0;
        cycle("lu_next");
        // The same pattern with rd = x0 does not stall.
        ex_load = 1; ex_rd_en = 1; ex_rd = 0; rs2 = 0;
        cycle("lu_x0");
        idle_inputs();

        // Mul at T, done at T+3.
        ex_valid = 1; ex_md = 1;
        cycle("mul_T");
        cycle("mul_T1");
        cycle("mul_T2");
        md_done = 1;
        cycle("mul_T3");
        ex_md = 0; ex_valid = 0;
        cycle("mul_T4");
        md_done = 0;

        // Mul at T, done at T+2 while MEM is stalled until T+4.
        ex_valid = 1; ex_md = 1;
        cycle("mdd_T");
        cycle("mdd_T1");
        md_done = 1; mem_req = 1; mem_ack = 0;
        cycle("mdd_T2");
        cycle("mdd_T3");
        mem_ack = 1;
        cycle("mdd_T4");
        chk("mdd_run_again", 32'(state), 32'd0);
        idle_inputs();
        cycle("mdd_T5");

        // Redirect and load-use in the same cycle: the redirect wins.
        ex_valid = 1; ex_load = 1; ex_rd_en = 1; ex_rd = 7; rs1_en = 1; rs1 = 7;
        redirect = 1;
        cycle("redir_lu");
        idle_inputs();

        // Redirect during a 2-cycle MEM stall. The flush happens on the ack cycle.
        ex_valid = 1; redirect = 1; mem_req = 1; mem_ack = 0;
        cycle("redir_ms0");
        cycle("redir_ms1");
        mem_ack = 1;
        cycle("redir_ack");
        idle_inputs();

        // Drive the stall counter into saturation.
        mem_req = 1;
        for (int i = 0; i < 18; i++) cycle("sat");
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        idle_inputs();
        // Start a mul, then reset asynchronously while MD_WAIT is active.
        ex_valid = 1; ex_md = 1;
        cycle("rst_mul_T");
        cycle("rst_mul_T1");
        chk("rst_hold15", 32'(stall_cnt), 32'd15);
        rst_n = 0;
        #1;
        chk("rst_async_state", 32'(state), 32'd0);
        chk("rst_async_cnt", 32'(stall_cnt), 32'd0);
        cycle("in_reset");
        idle_inputs();
        md_done = 1;
        rst_n = 1;
        #1;
        // A stale done after reset is ignored.
        cycle("stale_done");
        md_done = 0;

        // Random cycles.
        for (int n = 0; n < 400; n++) begin
            rs1_en   = ($urandom_range(0, 1) == 1);
            rs2_en   = ($urandom_range(0, 1) == 1);
            rs1      = RW'($urandom_range(0, 3));
            rs2      = RW'($urandom_range(0, 3));
            ex_valid = ($urandom_range(0, 9) < 7);
            ex_load  = ($urandom_range(0, 9) < 4);
            ex_rd_en = ($urandom_range(0, 9) < 8);
            ex_rd    = RW'($urandom_range(0, 3));
            ex_md    = ($urandom_range(0, 9) < 2);
            md_done  = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 9) < 2);
            mem_req  = ($urandom_range(0, 9) < 3);
            mem_ack  = ($urandom_range(0, 1) == 1);
            if (n == 200) begin
                rst_n = 0;
                #1;
            end else if (n == 203) begin
                rst_n = 1;
                #1;
            end
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
